// File: rtl/bus_cdc_gray_source.sv
// Source side of a gray-coded bus CDC: walks a binary count one step
// at a time toward a sampled target and registers its gray code.
//
// Ports:
//   SRC_CLOCK_I  - source clock, rising edge
//   SRC_RESET_I  - synchronous active-high reset
//   enable_i     - step enable; low freezes count, gray and hold timer
//   target_bus_i - binary value to converge to
//   gray_bus_o   - registered gray code of count (crosses the CDC)
//   count_o      - registered binary count
//   busy_o       - count differs from registered target
// Optional: BUS_CDC_SRC_HOLD_EN adds a HOLD state that keeps each
// gray value for g_HOLD_CYCLES source cycles.
module bus_cdc_gray_source #(
  parameter int g_BUS_WIDTH   = 32,
  parameter int g_HOLD_CYCLES = 2
) (
  input  logic                   SRC_CLOCK_I,
  input  logic                   SRC_RESET_I,
  input  logic                   enable_i,
  input  logic [g_BUS_WIDTH-1:0] target_bus_i,
  output logic [g_BUS_WIDTH-1:0] gray_bus_o,
  output logic [g_BUS_WIDTH-1:0] count_o,
  output logic                   busy_o
);

  localparam int W = g_BUS_WIDTH;
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

`ifdef BUS_CDC_SRC_HOLD_EN
  typedef enum logic [1:0] {
    IDLE,
    STEP,
    HOLD
  } state_t;

  localparam int HW = (g_HOLD_CYCLES > 2) ? $clog2(g_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(
    (g_HOLD_CYCLES > 1) ? g_HOLD_CYCLES - 2 : 0);

  logic [HW-1:0] hold_q, hold_d;
`else
  typedef enum logic [1:0] {
    IDLE,
    STEP
  } state_t;
`endif

  state_t state_q, state_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] gray_q, gray_d;
  logic [W-1:0] diff;

  // Modular distance; the tie (exactly half) steps up.
  assign diff = target_q - count_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_bus_i;
    count_d  = count_q;
    gray_d   = gray_q;
`ifdef BUS_CDC_SRC_HOLD_EN
    hold_d   = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (diff != '0 && enable_i)
          state_d = STEP;
      end
      STEP: begin
        if (diff == '0) begin
          state_d = IDLE;
        end else if (enable_i) begin
          if (diff <= HALF)
            count_d = count_q + 1'b1;
          else
            count_d = count_q - 1'b1;
          gray_d = count_d ^ (count_d >> 1);
`ifdef BUS_CDC_SRC_HOLD_EN
          if (g_HOLD_CYCLES > 1) begin
            state_d = HOLD;
            hold_d  = '0;
          end
`endif
        end
      end
`ifdef BUS_CDC_SRC_HOLD_EN
      HOLD: begin
        if (enable_i) begin
          if (hold_q == HOLD_LAST) begin
            state_d = STEP;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SRC_CLOCK_I) begin
    if (SRC_RESET_I) begin
      state_q  <= IDLE;
      target_q <= '0;
      count_q  <= '0;
      gray_q   <= '0;
`ifdef BUS_CDC_SRC_HOLD_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      gray_q   <= gray_d;
`ifdef BUS_CDC_SRC_HOLD_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign gray_bus_o = gray_q;
  assign count_o    = count_q;
  assign busy_o     = (diff != '0);

endmodule
